// File: rtl/q4_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and its caller / unit under test.
// slave is the sequencer side; master is the caller side (golden tables, start/abort, unit feedback).
interface q4_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] expected_d;
  logic [7:0] expected_e;
  logic       a;
  logic       b;
  logic       c;
  logic       d_in;
  logic       e_in;
  logic       busy;
  logic       done;
  logic [7:0] result_d;
  logic [7:0] result_e;
  logic       mismatch;
  logic [2:0] fail_idx;

  modport master (
    output start, abort, expected_d, expected_e, d_in, e_in,
    input  a, b, c, busy, done, result_d, result_e, mismatch, fail_idx
  );

  modport slave (
    input  start, abort, expected_d, expected_e, d_in, e_in,
    output a, b, c, busy, done, result_d, result_e, mismatch, fail_idx
  );
endinterface

// File: rtl/q4_sweep_ctrl.sv
// Self-test sequencer: sweeps a 3-in/2-out combinational unit through all 8 vectors,
// captures d/e truth tables and flags the first vector that disagrees with golden.
//   state | meaning
//   IDLE  | waiting for start, stimulus parked at 000
//   APPLY | driving vec, sampling after HOLD_CYCLES cycles
//   DONE  | one-cycle completion pulse
module q4_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  q4_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gold_d_q, gold_d_d;
  logic [7:0]       gold_e_q, gold_e_d;
  logic [7:0]       res_d_q, res_d_d;
  logic [7:0]       res_e_q, res_e_d;
  logic             mism_q, mism_d;
  logic [2:0]       fidx_q, fidx_d;
  logic [2:0]       abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    gold_d_d = gold_d_q;
    gold_e_d = gold_e_q;
    res_d_d  = res_d_q;
    res_e_d  = res_e_q;
    mism_d   = mism_q;
    fidx_d   = fidx_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          gold_d_d = bus.expected_d;
          gold_e_d = bus.expected_e;
          res_d_d  = 8'h00;
          res_e_d  = 8'h00;
          mism_d   = 1'b0;
          fidx_d   = 3'd0;
          vec_d    = 3'd0;
          cnt_d    = '0;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        // abort takes priority, even over the final sample
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          res_d_d[vec_q] = bus.d_in;
          res_e_d[vec_q] = bus.e_in;
          if (((bus.d_in != gold_d_q[vec_q]) || (bus.e_in != gold_e_q[vec_q])) && !mism_q) begin
            mism_d = 1'b1;
            fidx_d = vec_q;
          end
          if (vec_q == 3'd7) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 3'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are registered from the next-state view so they line up with state_q
    busy_d = (state_d == APPLY);
    done_d = (state_d == DONE);
    abc_d  = (state_d == APPLY) ? vec_d : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 3'd0;
      cnt_q    <= '0;
      gold_d_q <= 8'h00;
      gold_e_q <= 8'h00;
      res_d_q  <= 8'h00;
      res_e_q  <= 8'h00;
      mism_q   <= 1'b0;
      fidx_q   <= 3'd0;
      abc_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      gold_d_q <= gold_d_d;
      gold_e_q <= gold_e_d;
      res_d_q  <= res_d_d;
      res_e_q  <= res_e_d;
      mism_q   <= mism_d;
      fidx_q   <= fidx_d;
      abc_q    <= abc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.a        = abc_q[2];
  assign bus.b        = abc_q[1];
  assign bus.c        = abc_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result_d = res_d_q;
  assign bus.result_e = res_e_q;
  assign bus.mismatch = mism_q;
  assign bus.fail_idx = fidx_q;

endmodule

// File: tb/tb_q4_sweep_ctrl.sv
// Bench for q4_sweep_ctrl: H=4 and H=1 instances driven by directed and random sweeps,
// every cycle compared against a cycle-indexed model of the sweep timeline.
module tb_q4_sweep_ctrl;

  localparam int H4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] flip_d = 8'h00;
  logic [7:0] flip_e = 8'h00;

  always #5 clk = ~clk;

  q4_sweep_ctrl_if if4 ();
  q4_sweep_ctrl_if if1 ();

  q4_sweep_ctrl #(.HOLD_CYCLES(H4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  q4_sweep_ctrl #(.HOLD_CYCLES(1),  .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // unit under test: d = parity, e = majority, optionally corrupted per vector
  assign if4.d_in = (if4.a ^ if4.b ^ if4.c) ^ flip_d[{if4.a, if4.b, if4.c}];
  assign if4.e_in = ((if4.a & if4.b) | (if4.a & if4.c) | (if4.b & if4.c)) ^ flip_e[{if4.a, if4.b, if4.c}];
  assign if1.d_in = (if1.a ^ if1.b ^ if1.c) ^ flip_d[{if1.a, if1.b, if1.c}];
  assign if1.e_in = ((if1.a & if1.b) | (if1.a & if1.c) | (if1.b & if1.c)) ^ flip_e[{if1.a, if1.b, if1.c}];

  wire [24:0] obs4 = {if4.a, if4.b, if4.c, if4.busy, if4.done, if4.result_d, if4.result_e,
                      if4.mismatch, if4.fail_idx};
  wire [24:0] obs1 = {if1.a, if1.b, if1.c, if1.busy, if1.done, if1.result_d, if1.result_e,
                      if1.mismatch, if1.fail_idx};

  // expected outputs in cycle t of a sweep (start accepted at edge 0), abort raised in cycle ab (0 = none)
  function automatic logic [24:0] exp_at(int h, int t, int ab, logic [7:0] gd, logic [7:0] ge);
    int         te;
    int         ns;
    bit         live;
    logic [2:0] abc;
    logic       bsy, dn, mm, ud, ue;
    logic [7:0] rd, re;
    logic [2:0] fi;
    te = t; live = 1'b1;
    if (ab > 0 && t > ab) begin te = ab; live = 1'b0; end
    ns = (te >= 1) ? (te - 1) / h : 0;
    if (ns > 8) ns = 8;
    bsy = live && t >= 1 && t <= 8 * h;
    abc = bsy ? 3'((t - 1) / h) : 3'd0;
    dn  = live && (t == 8 * h + 1);
    rd = 8'h00; re = 8'h00; mm = 1'b0; fi = 3'd0;
    for (int k = 0; k < ns; k++) begin
      ud = logic'(($countones(k) % 2) == 1) ^ flip_d[k];
      ue = logic'($countones(k) >= 2) ^ flip_e[k];
      rd[k] = ud;
      re[k] = ue;
      if ((ud != gd[k] || ue != ge[k]) && !mm) begin
        mm = 1'b1;
        fi = 3'(k);
      end
    end
    return {abc, bsy, dn, rd, re, mm, fi};
  endfunction

  task automatic check(string tag, logic [24:0] o, logic [24:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(logic [7:0] gd, logic [7:0] ge, int ab, bit sa, int rst_at);
    if4.expected_d = gd;
    if4.expected_e = ge;
    if4.start = 1'b1;
    if4.abort = sa;
    step();
    if4.start = 1'b0;
    if4.abort = 1'b0;
    if4.expected_d = 8'($urandom);
    if4.expected_e = 8'($urandom);
    for (int t = 1; t <= 8 * H4 + 2; t++) begin
      if (t == ab) if4.abort = 1'b1;
      // start while busy or in DONE must be ignored; after an abort it would restart
      if4.start = ((ab == 0 || t <= ab) && t <= 8 * H4 + 1 && rst_at == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      check($sformatf("sweep4 t=%0d ab=%0d", t, ab), obs4, exp_at(H4, t, ab, gd, ge));
      if (t == rst_at) begin
        #3 rst_n = 1'b0;
        #1;
        check("async_rst dut4", obs4, 25'd0);
        check("async_rst dut1", obs1, 25'd0);
        return;
      end
      step();
      if4.abort = 1'b0;
    end
    if4.start = 1'b0;
  endtask

  initial begin
    logic [7:0] gd, ge;
    int         ab;
    if4.start = 1'b0; if4.abort = 1'b0; if4.expected_d = 8'h00; if4.expected_e = 8'h00;
    if1.start = 1'b0; if1.abort = 1'b0; if1.expected_d = 8'h00; if1.expected_e = 8'h00;

    repeat (3) step();
    check("reset dut4", obs4, 25'd0);
    check("reset dut1", obs1, 25'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle dut4 %0d", i), obs4, 25'd0);
      check($sformatf("idle dut1 %0d", i), obs1, 25'd0);
    end

    run4(8'h96, 8'hE8, 0, 1'b0, 0);
    run4(8'h9E, 8'hEA, 0, 1'b0, 0);
    run4(8'h96, 8'hE8, 10, 1'b0, 0);
    run4(8'h96, 8'hE8, 0, 1'b0, 0);
    run4(8'h96, 8'hE8, 8 * H4, 1'b0, 0);
    run4(8'h96, 8'hE8, 0, 1'b1, 0);

    // continuous start on the H=1 instance: sweep, DONE, IDLE, second sweep from cycle 11
    if1.expected_d = 8'h96;
    if1.expected_e = 8'hE8;
    if1.start = 1'b1;
    step();
    for (int t = 1; t <= 20; t++) begin
      check($sformatf("held_start t=%0d", t), obs1,
            (t <= 10) ? exp_at(1, t, 0, 8'h96, 8'hE8) : exp_at(1, t - 10, 0, 8'h96, 8'hE8));
      if (t == 20) if1.start = 1'b0;
      step();
    end

    for (int r = 0; r < 5; r++) begin
      flip_d = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      flip_e = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      gd = ($urandom_range(0, 1) == 1) ? (8'h96 ^ flip_d) : 8'($urandom);
      ge = ($urandom_range(0, 1) == 1) ? (8'hE8 ^ flip_e) : 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8 * H4)) : 0;
      run4(gd, ge, ab, 1'b0, 0);
    end

    flip_d = 8'h00;
    flip_e = 8'h00;
    run4(8'h96, 8'hE8, 0, 1'b0, 22);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst dut4 %0d", i), obs4, 25'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
